// File: rtl/up_gen2_if.sv
// up_gen2_if -- program ROM and data RAM bus of the up_gen2 micro-sequencer.
//
// Signals:
//   rom_addr  : program address (current pc)
//   rom_data  : program byte {opcode, operand}, combinational from rom_addr
//   ram_addr  : data address {oprnd, address byte}
//   ram_req   : RAM request, high for every cycle of a memory access
//   ram_we    : write qualifier (store)
//   ram_wdata : write data (accumulator)
//   ram_rdata : read data
//   ram_ack   : access completion
//
// Modports: master = sequencer side, slave = memory side.
interface up_gen2_if #(
    parameter int unsigned DATA_W = 4
) ();
    logic [11:0]       rom_addr;
    logic [7:0]        rom_data;
    logic [11:0]       ram_addr;
    logic              ram_req;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    modport master (
        output rom_addr,
        input  rom_data,
        output ram_addr,
        output ram_req,
        output ram_we,
        output ram_wdata,
        input  ram_rdata,
        input  ram_ack
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  ram_addr,
        input  ram_req,
        input  ram_we,
        input  ram_wdata,
        output ram_rdata,
        output ram_ack
    );
endinterface

// File: rtl/up_gen2.sv
// up_gen2 -- accumulator micro-sequencer with 4-bit opcodes, 12-bit program counter,
// a handshaked data RAM and IO_CH registered input/output channels.
//
// Ports:
//   clock     : single clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : ROM/RAM bus (up_gen2_if.master)
//   in_ports  : input channels, channel k at [k*DATA_W +: DATA_W]
//   out_ports : registered output channels
//   out_valid : one-cycle write strobe per output channel
//   accu, c_flag, z_flag, pc, instr, oprnd, state : debug visibility
//   mem_err   : sticky RAM timeout error
//
// Optional feature: define UP_GEN2_MEM_TIMEOUT_EN to abort a memory access after
// MEM_TIMEOUT cycles without ram_ack. Without it MEM waits indefinitely and mem_err is 0.
module up_gen2 #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned IO_CH       = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    up_gen2_if.master               bus,
    input  logic [IO_CH*DATA_W-1:0] in_ports,
    output logic [IO_CH*DATA_W-1:0] out_ports,
    output logic [IO_CH-1:0]        out_valid,
    output logic [DATA_W-1:0]       accu,
    output logic                    c_flag,
    output logic                    z_flag,
    output logic [11:0]             pc,
    output logic [3:0]              instr,
    output logic [3:0]              oprnd,
    output logic [1:0]              state,
    output logic                    mem_err
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [11:0]       pc_q, pc_d;
    logic [3:0]        instr_q, instr_d;
    logic [3:0]        oprnd_q, oprnd_d;
    logic [DATA_W-1:0] accu_q, accu_d;
    logic              c_q, c_d;
    logic              z_q, z_d;

    logic [11:0]       pc_inc;
    logic              is_jump, jump_taken, is_mem;
    logic [DATA_W-1:0] in_val, operand_b;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_r, alu_a;
    logic              alu_c;
    logic              alu_wr, out_wr;
    logic              timeout;

    assign pc_inc = pc_q + 12'd1;  // wraps 0xFFF -> 0x000

    // Instruction class and jump condition
    always_comb begin
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        is_mem     = 1'b0;
        case (instr_q)
            OP_JC:  begin is_jump = 1'b1; jump_taken = c_q;  end
            OP_JNC: begin is_jump = 1'b1; jump_taken = !c_q; end
            OP_JZ:  begin is_jump = 1'b1; jump_taken = z_q;  end
            OP_JNZ: begin is_jump = 1'b1; jump_taken = !z_q; end
            OP_JMP: begin is_jump = 1'b1; jump_taken = 1'b1; end
            OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM: is_mem = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range channels read as zero
    always_comb begin
        in_val = '0;
        for (int k = 0; k < IO_CH; k++) begin
            if (oprnd_q == 4'(k)) in_val = in_ports[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        if (is_mem)                operand_b = bus.ram_rdata;
        else if (instr_q == OP_IN) operand_b = in_val;
        else                       operand_b = DATA_W'(oprnd_q);
    end

    // ALU: alu_r drives the zero flag, alu_a is the new accumulator value
    always_comb begin
        sum  = {1'b0, accu_q} + {1'b0, operand_b};
        diff = {1'b0, accu_q} - {1'b0, operand_b};
        case (instr_q)
            OP_ADDI, OP_ADDM: begin
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
                alu_a = sum[DATA_W-1:0];
            end
            OP_CMPI, OP_CMPM: begin
                alu_r = diff[DATA_W-1:0];
                alu_c = diff[DATA_W];  // borrow: operand greater than accu
                alu_a = accu_q;
            end
            OP_NANDI, OP_NANDM: begin
                alu_r = ~(accu_q & operand_b);
                alu_c = 1'b0;
                alu_a = ~(accu_q & operand_b);
            end
            default: begin  // LIT, IN, LD
                alu_r = operand_b;
                alu_c = 1'b0;
                alu_a = operand_b;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        accu_d  = accu_q;
        c_d     = c_q;
        z_d     = z_q;
        alu_wr  = 1'b0;
        out_wr  = 1'b0;
        case (state_q)
            FETCH: begin
                {instr_d, oprnd_d} = bus.rom_data;
                pc_d               = pc_inc;
                state_d            = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                if (is_jump) begin
                    // pc points at the address byte: take it or skip it
                    pc_d = jump_taken ? {oprnd_q, bus.rom_data} : pc_inc;
                end else if (is_mem) begin
                    state_d = MEM;
                end else if (instr_q == OP_OUT) begin
                    out_wr = 1'b1;
                end else begin
                    alu_wr = 1'b1;
                end
            end
            MEM: begin
                if (bus.ram_ack) begin
                    alu_wr  = (instr_q != OP_ST);
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end else if (timeout) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (alu_wr) begin
            accu_d = alu_a;
            c_d    = alu_c;
            z_d    = (alu_r == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            oprnd_q <= '0;
            accu_q  <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            accu_q  <= accu_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Output channels: strobe is high the cycle after the OUT execute edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_ports <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= '0;
            for (int k = 0; k < IO_CH; k++) begin
                if (out_wr && oprnd_q == 4'(k)) begin
                    out_ports[k*DATA_W +: DATA_W] <= accu_q;
                    out_valid[k]                  <= 1'b1;
                end
            end
        end
    end

`ifdef UP_GEN2_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    // Last allowed MEM cycle; an ack in that same cycle still completes the op
    assign timeout = (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = (state_q == MEM && state_d == MEM) ? wait_cnt_q + 1'b1 : '0;
        mem_err_d  = mem_err_q | (state_q == MEM && !bus.ram_ack && timeout);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign bus.rom_addr  = pc_q;
    assign bus.ram_addr  = {oprnd_q, bus.rom_data};
    assign bus.ram_req   = (state_q == MEM);
    assign bus.ram_we    = (state_q == MEM) && (instr_q == OP_ST);
    assign bus.ram_wdata = accu_q;

    assign accu   = accu_q;
    assign c_flag = c_q;
    assign z_flag = z_q;
    assign pc     = pc_q;
    assign instr  = instr_q;
    assign oprnd  = oprnd_q;
    assign state  = state_q;
endmodule

// File: tb/tb_up_gen2.sv
// tb_up_gen2 -- self-checking bench for up_gen2: directed program, random program
// against an instruction-level reference model, timeout and reset-during-MEM cases.
module tb_up_gen2;
    localparam int unsigned DW   = 4;
    localparam int unsigned NCH  = 2;
    localparam int unsigned TMO  = 15;
    localparam int          MASK = (1 << DW) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NCH*DW-1:0] in_ports = '0;
    logic [NCH*DW-1:0] out_ports;
    logic [NCH-1:0]    out_valid;
    logic [DW-1:0]     accu;
    logic              c_flag, z_flag;
    logic [11:0]       pc;
    logic [3:0]        instr, oprnd;
    logic [1:0]        state;
    logic              mem_err;

    logic [7:0]    rom     [4096];
    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] ref_ram [4096];

    int n_chk = 0;
    int n_err = 0;

    // Architectural reference state
    int m_pc, m_a, m_c, m_z, m_err;
    int m_out [NCH];
    int last_cyc, last_req;

    up_gen2_if #(.DATA_W(DW)) bus ();

    assign bus.rom_data  = rom[bus.rom_addr];
    assign bus.ram_rdata = mem[bus.ram_addr];

    up_gen2 #(
        .DATA_W      (DW),
        .IO_CH       (NCH),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .out_valid (out_valid),
        .accu      (accu),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .pc        (pc),
        .instr     (instr),
        .oprnd     (oprnd),
        .state     (state),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc  = 0;
        m_a   = 0;
        m_c   = 0;
        m_z   = 0;
        m_err = 0;
        for (int k = 0; k < NCH; k++) m_out[k] = 0;
    endfunction

    function automatic void model_alu(input int op, input int b);
        int s;
        case (op)
            'hA, 'hB: begin
                s   = m_a + b;
                m_c = (s > MASK);
                m_a = s & MASK;
                m_z = (m_a == 0);
            end
            'h2, 'h3: begin
                m_c = (b > m_a);
                m_z = (b == m_a);
            end
            'hE, 'hF: begin
                m_a = ~(m_a & b) & MASK;
                m_c = 0;
                m_z = (m_a == 0);
            end
            default: begin
                m_a = b;
                m_c = 0;
                m_z = (b == 0);
            end
        endcase
    endfunction

    task automatic reset_dut();
        reset        = 1'b0;
        bus.ram_ack  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // Execute one instruction starting at a FETCH-state negedge; hang = never ack
    task automatic step_instr(input int delay, input bit hang);
        logic [31:0]       rnd;
        int                ib, nb, op, opr, addr, pre_a, exp_cyc, exp_mem, cyc, req_cyc, wa, wd;
        bit                taken, wr_pend, ack;
        logic [NCH-1:0]    exp_v;
        logic [NCH*DW-1:0] exp_ports;
        logic [31:0]       tmp;

        rnd      = $urandom;
        in_ports = rnd[NCH*DW-1:0];
        ib       = rom[m_pc];
        nb       = rom[(m_pc + 1) & 'hFFF];
        op       = ib >> 4;
        opr      = ib & 'hF;
        addr     = (opr << 8) | nb;
        pre_a    = m_a;
        exp_v    = '0;
        exp_mem  = 0;
        exp_cyc  = 2;
        case (op)
            'h0, 'h1, 'h8, 'h9, 'hC: begin
                case (op)
                    'h0:     taken = (m_c != 0);
                    'h1:     taken = (m_c == 0);
                    'h8:     taken = (m_z != 0);
                    'h9:     taken = (m_z == 0);
                    default: taken = 1'b1;
                endcase
                m_pc = taken ? addr : ((m_pc + 2) & 'hFFF);
            end
            'h3, 'h6, 'h7, 'hB, 'hF: begin
                m_pc = (m_pc + 2) & 'hFFF;
                if (hang) begin
                    exp_mem = TMO;
                    m_err   = 1;
                end else begin
                    exp_mem = delay + 1;
                    if (op == 7) begin
                        tmp           = m_a;
                        ref_ram[addr] = tmp[DW-1:0];
                    end else begin
                        model_alu(op, ref_ram[addr]);
                    end
                end
                exp_cyc = 2 + exp_mem;
            end
            'hD: begin
                m_pc = (m_pc + 1) & 'hFFF;
                if (opr < NCH) begin
                    m_out[opr] = m_a;
                    exp_v[opr] = 1'b1;
                end
            end
            'h5: begin
                m_pc = (m_pc + 1) & 'hFFF;
                model_alu(op, (opr < NCH) ? int'(in_ports[opr*DW +: DW]) : 0);
            end
            default: begin
                m_pc = (m_pc + 1) & 'hFFF;
                model_alu(op, opr);
            end
        endcase

        cyc     = 0;
        req_cyc = 0;
        wr_pend = 1'b0;
        do begin
            if (bus.ram_req) begin
                req_cyc++;
                check_eq("ram_addr", bus.ram_addr, addr);
                check_eq("ram_we", bus.ram_we, (op == 7));
                check_eq("ram_wdata", bus.ram_wdata, pre_a);
                ack = !hang && (req_cyc > delay);
                if (ack && bus.ram_we) begin
                    wr_pend = 1'b1;
                    wa      = bus.ram_addr;
                    wd      = bus.ram_wdata;
                end
            end else begin
                ack = 1'($urandom_range(0, 1));  // must be ignored outside MEM
            end
            bus.ram_ack = ack;
            @(negedge clock);
            cyc++;
            if (wr_pend) begin
                tmp     = wd;
                mem[wa] = tmp[DW-1:0];
                wr_pend = 1'b0;
            end
        end while (state != 2'd0 && cyc < 64);

        last_cyc = cyc;
        last_req = req_cyc;
        for (int k = 0; k < NCH; k++) begin
            tmp                    = m_out[k];
            exp_ports[k*DW +: DW] = tmp[DW-1:0];
        end
        check_eq("cycles", cyc, exp_cyc);
        check_eq("req_cycles", req_cyc, exp_mem);
        check_eq("pc", pc, m_pc);
        check_eq("accu", accu, m_a);
        check_eq("c_flag", c_flag, m_c);
        check_eq("z_flag", z_flag, m_z);
        check_eq("mem_err", mem_err, m_err);
        check_eq("out_valid", out_valid, exp_v);
        check_eq("out_ports", out_ports, exp_ports);
        if (op == 7 && !hang) check_eq("ram_store", mem[addr], ref_ram[addr]);
    endtask

    initial begin
        logic [31:0] r;
        bus.ram_ack = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            r          = $urandom;
            rom[i]     = r[7:0];
            r          = $urandom;
            mem[i]     = r[DW-1:0];
            ref_ram[i] = r[DW-1:0];
        end
        // Directed program
        rom[12'h000] = 8'h45;  rom[12'h001] = 8'hA3;  rom[12'h002] = 8'hD0;
        rom[12'h003] = 8'h4F;  rom[12'h004] = 8'hA1;
        rom[12'h005] = 8'h80;  rom[12'h006] = 8'h40;
        rom[12'h040] = 8'h41;  rom[12'h041] = 8'h22;
        rom[12'h042] = 8'h80;  rom[12'h043] = 8'h50;
        rom[12'h044] = 8'h71;  rom[12'h045] = 8'h23;
        rom[12'h046] = 8'h53;  rom[12'h047] = 8'hD3;  rom[12'h048] = 8'h51;
        rom[12'h049] = 8'h61;  rom[12'h04A] = 8'h23;
        rom[12'h04B] = 8'hCF;  rom[12'h04C] = 8'hFF;
        rom[12'hFFF] = 8'hC1;  // address byte wraps to rom[0] = 0x45 -> 0x145

        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_state", state, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_accu", accu, 0);
        check_eq("rst_flags", {c_flag, z_flag}, 0);
        check_eq("rst_out", {out_ports, out_valid}, 0);
        check_eq("rst_req", bus.ram_req, 0);
        check_eq("rst_mem_err", mem_err, 0);
        reset_dut();

        step_instr(0, 0);  check_eq("lit5", accu, 5);
        step_instr(0, 0);  check_eq("addi3", accu, 8);
        check_eq("addi3_flags", {c_flag, z_flag}, 0);
        step_instr(0, 0);  check_eq("out0_data", out_ports[DW-1:0], 8);
        check_eq("out0_valid", out_valid, 1);
        step_instr(0, 0);
        step_instr(0, 0);  check_eq("addi_wrap", {c_flag, z_flag, accu}, {2'b11, 4'h0});
        step_instr(0, 0);  check_eq("jz_taken", pc, 12'h040);
        step_instr(0, 0);
        step_instr(0, 0);  check_eq("cmpi_gt", {c_flag, accu}, {1'b1, 4'h1});
        step_instr(0, 0);  check_eq("jz_not_taken", pc, 12'h044);
        step_instr(3, 0);  check_eq("st_cycles", last_cyc, 6);
        check_eq("st_req", last_req, 4);
        check_eq("st_data", mem[12'h123], 1);
        step_instr(0, 0);  check_eq("in_bad_ch", {z_flag, accu}, {1'b1, 4'h0});
        step_instr(0, 0);  check_eq("out_bad_ch", {out_valid, out_ports}, {2'b00, 4'h0, 4'h8});
        step_instr(0, 0);
        step_instr(1, 0);  check_eq("ld_back", accu, 1);
        step_instr(0, 0);  check_eq("jmp_fff", pc, 12'hFFF);
        step_instr(0, 0);  check_eq("pc_wrap_jmp", pc, 12'h145);

        // Random program from wherever the directed code left off
        repeat (400) step_instr($urandom_range(0, 3), 0);

`ifdef UP_GEN2_MEM_TIMEOUT_EN
        rom[12'h000] = 8'h61;
        rom[12'h001] = 8'h23;
        reset_dut();
        step_instr(0, 1);
        check_eq("tmo_req", last_req, TMO);
        check_eq("tmo_err", mem_err, 1);
        check_eq("tmo_accu", accu, 0);
`endif

        // Reset while a store is waiting in MEM
        rom[12'h000] = 8'h73;
        rom[12'h001] = 8'hAB;
        reset_dut();
        check_eq("err_cleared", mem_err, 0);
        bus.ram_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("mid_mem_req", bus.ram_req, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_mem_req", bus.ram_req, 0);
        check_eq("rst_mem_state", state, 0);
        bus.ram_ack = 1'b1;
        @(negedge clock);
        check_eq("rst_hold_req", bus.ram_req, 0);
        reset = 1'b1;
        model_reset();
        step_instr(0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
